// File: rtl/si5324_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : si5324_cfg_sequencer
// Description : Walks the SI5324 (reg,value) table after a power-up delay and
//               issues one I2C write command per entry to the byte-level
//               master. Optional NACK retry is enabled by SI5324_CFG_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module si5324_cfg_sequencer #(
    parameter int         NUM_REGS   = 43,
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         PWRUP_CYC  = 1000,
    parameter int         MAX_RETRY  = 3,
    parameter int         AUTO_START = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RECONFIG,
    output logic [7:0]  rom_idx,
    input  logic [15:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_dev,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_idx
);

    localparam int                 c_cnt_w    = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(PWRUP_CYC - 1);
    localparam logic [7:0]         c_last_idx = 8'(NUM_REGS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_pwrup = 3'd1;
    localparam logic [2:0] c_st_fetch = 3'd2;
    localparam logic [2:0] c_st_load  = 3'd3;
    localparam logic [2:0] c_st_issue = 3'd4;
    localparam logic [2:0] c_st_wait  = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;
    localparam logic [2:0] c_st_error = 3'd7;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_delay;
    logic               r_auto;
    logic [7:0]         r_rom_idx;
    logic [7:0]         r_cmd_reg;
    logic [7:0]         r_cmd_data;
    logic [7:0]         r_err_idx;
    logic               w_start;
    logic               w_retry_ok;

    // r_auto is only ever set by reset, so it acts as a one-shot start in IDLE.
    assign w_start = r_auto || RECONFIG;

`ifdef SI5324_CFG_RETRY_EN
    logic [7:0] r_retry;
    assign w_retry_ok = (r_retry < 8'(MAX_RETRY));
`else
    logic [7:0] w_unused_max_retry;
    assign w_unused_max_retry = 8'(MAX_RETRY);
    assign w_retry_ok         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_delay    <= '0;
            r_auto     <= (AUTO_START != 0);
            r_rom_idx  <= 8'd0;
            r_cmd_reg  <= 8'd0;
            r_cmd_data <= 8'd0;
            r_err_idx  <= 8'd0;
`ifdef SI5324_CFG_RETRY_EN
            r_retry    <= 8'd0;
`endif
        end else begin
            case (r_state)
                c_st_idle, c_st_done, c_st_error: begin
                    if (w_start) begin
                        r_auto    <= 1'b0;
                        r_rom_idx <= 8'd0;
                        r_delay   <= c_cnt_load;
                        r_state   <= c_st_pwrup;
                    end
                end
                c_st_pwrup: begin
                    if (r_delay == '0) begin
                        r_state <= c_st_fetch;
                    end else begin
                        r_delay <= r_delay - 1'b1;
                    end
                end
                c_st_fetch: begin
                    r_state <= c_st_load;
                end
                c_st_load: begin
                    r_cmd_reg  <= rom_data[15:8];
                    r_cmd_data <= rom_data[7:0];
`ifdef SI5324_CFG_RETRY_EN
                    r_retry    <= 8'd0;
`endif
                    r_state    <= c_st_issue;
                end
                c_st_issue: begin
                    if (cmd_ready) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (rsp_valid) begin
                        if (!rsp_nack) begin
                            if (r_rom_idx == c_last_idx) begin
                                r_state <= c_st_done;
                            end else begin
                                r_rom_idx <= r_rom_idx + 8'd1;
                                r_state   <= c_st_fetch;
                            end
                        end else if (w_retry_ok) begin
`ifdef SI5324_CFG_RETRY_EN
                            r_retry <= r_retry + 8'd1;
`endif
                            r_state <= c_st_issue;
                        end else begin
                            r_err_idx <= r_rom_idx;
                            r_state   <= c_st_error;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rom_idx   = r_rom_idx;
    assign cmd_valid = (r_state == c_st_issue);
    assign cmd_dev   = DEV_ADDR;
    assign cmd_reg   = r_cmd_reg;
    assign cmd_data  = r_cmd_data;
    assign busy      = (r_state == c_st_pwrup) || (r_state == c_st_fetch) ||
                       (r_state == c_st_load)  || (r_state == c_st_issue) ||
                       (r_state == c_st_wait);
    assign done      = (r_state == c_st_done);
    assign error     = (r_state == c_st_error);
    assign err_idx   = r_err_idx;

endmodule
`default_nettype wire
